// File: rtl/dab_gate_driver_if.sv
// Command/gate bundle between the DAB pattern generator, the gate driver and the gate pins.
// The pattern generator side is the master; the gate driver is the slave.
interface dab_gate_driver_if #(
  parameter int DT_W = 8
);
  logic            en;
  logic [DT_W-1:0] deadtime;
  logic [1:0]      V1;
  logic [1:0]      V2;
  logic [3:0]      Sp;
  logic [3:0]      Ss;
  logic            fault;
  logic            dt_busy;

  modport master (
    output en, deadtime, V1, V2,
    input  Sp, Ss, fault, dt_busy
  );

  modport slave (
    input  en, deadtime, V1, V2,
    output Sp, Ss, fault, dt_busy
  );
endinterface

// File: rtl/dab_gate_driver.sv
// DAB gate driver: maps V1/V2 levels onto four half-bridge legs, each with deadtime and a sticky illegal-code fault.
// Optional feature: define MIN_ON_TIME_EN to hold each on-state for at least MIN_ON cycles.
module dab_gate_driver #(
  parameter int DT_W   = 8,
  parameter int MIN_ON = 16
) (
  input  logic              clk,
  input  logic              rst,
  dab_gate_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DT    = 2'd1,
    ON_HI = 2'd2,
    ON_LO = 2'd3
  } leg_state_t;

  logic [1:0]      v1_reg;
  logic [1:0]      v2_reg;
  logic            fault_reg;
  logic            illegal;
  logic            force_off;
  logic [DT_W-1:0] dt_load;
  logic [3:0]      target_hi;
  logic [7:0]      gate_reg;
  logic [3:0]      busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg    <= 2'b00;
      v2_reg    <= 2'b00;
      fault_reg <= 1'b0;
    end else begin
      v1_reg    <= bus.V1;
      v2_reg    <= bus.V2;
      fault_reg <= fault_reg | illegal;
    end
  end

  // The illegal code already forces the legs off on the edge that latches the fault.
  assign illegal   = (v1_reg == 2'b10) || (v2_reg == 2'b10);
  assign force_off = !bus.en || fault_reg || illegal;
  assign dt_load   = (bus.deadtime == '0) ? DT_W'(1) : bus.deadtime;

  // Leg order: 0=PA, 1=PB, 2=SA, 3=SB. A level of 0 parks both legs low.
  assign target_hi[0] = (v1_reg == 2'b01);
  assign target_hi[1] = (v1_reg == 2'b11);
  assign target_hi[2] = (v2_reg == 2'b01);
  assign target_hi[3] = (v2_reg == 2'b11);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_leg
      leg_state_t      state_reg;
      leg_state_t      state_next;
      logic [DT_W-1:0] cnt_reg;
      logic [DT_W-1:0] cnt_next;
      logic            want_move;
      logic            on_done;

`ifdef MIN_ON_TIME_EN
      localparam int ON_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
      logic [ON_W-1:0] on_cnt_reg;
      logic [ON_W-1:0] on_cnt_next;

      // on_cnt_reg holds (cycles already on - 1); saturates once the minimum is met.
      assign on_done = (on_cnt_reg >= ON_W'(MIN_ON - 1));

      always_comb begin
        on_cnt_next = '0;
        if (state_reg == ON_HI || state_reg == ON_LO) begin
          on_cnt_next = on_done ? on_cnt_reg : on_cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          on_cnt_reg <= '0;
        end else begin
          on_cnt_reg <= on_cnt_next;
        end
      end
`else
      assign on_done = 1'b1;
`endif

      assign want_move = ((state_reg == ON_HI) && !target_hi[gi]) ||
                         ((state_reg == ON_LO) &&  target_hi[gi]);

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          OFF: begin
            if (!force_off) begin
              state_next = DT;
              cnt_next   = dt_load;
            end
          end
          DT: begin
            if (force_off) begin
              state_next = OFF;
            end else if (cnt_reg <= DT_W'(1)) begin
              state_next = target_hi[gi] ? ON_HI : ON_LO;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          ON_HI, ON_LO: begin
            if (force_off) begin
              state_next = OFF;
            end else if (want_move && on_done) begin
              state_next = DT;
              cnt_next   = dt_load;
            end
          end
          default: begin
            state_next = OFF;
          end
        endcase
      end

      // Gate pins are registered from the next state so they change on the same edge as the FSM.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg          <= OFF;
          cnt_reg            <= '0;
          gate_reg[2*gi]     <= 1'b0;
          gate_reg[2*gi + 1] <= 1'b0;
          busy_reg[gi]       <= 1'b0;
        end else begin
          state_reg          <= state_next;
          cnt_reg            <= cnt_next;
          gate_reg[2*gi]     <= (state_next == ON_HI);
          gate_reg[2*gi + 1] <= (state_next == ON_LO);
          busy_reg[gi]       <= (state_next == DT);
        end
      end
    end
  endgenerate

  assign bus.Sp      = gate_reg[3:0];
  assign bus.Ss      = gate_reg[7:4];
  assign bus.fault   = fault_reg;
  assign bus.dt_busy = |busy_reg;

endmodule

// File: tb/tb_dab_gate_driver.sv
// Scoreboard bench for dab_gate_driver: stimulus queues expected output changes with their edge number,
// a negedge monitor pops one entry per observed change and checks leg exclusivity every cycle.
module tb_dab_gate_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  typedef struct {
    int         at;
    logic [9:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] prev;
  logic [9:0] obs;

  dab_gate_driver_if #(.DT_W(8)) bus ();

  dab_gate_driver #(.DT_W(8), .MIN_ON(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {bus.fault, bus.dt_busy, bus.Ss, bus.Sp};

  task automatic expect_at(input int at, input logic f, input logic busy,
                           input logic [3:0] ss, input logic [3:0] sp);
    exp_t e;
    e.at  = at;
    e.val = {f, busy, ss, sp};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      checks++;
      if ((bus.Sp[0] & bus.Sp[1]) | (bus.Sp[2] & bus.Sp[3]) |
          (bus.Ss[0] & bus.Ss[1]) | (bus.Ss[2] & bus.Ss[3])) begin
        errors++;
        $display("FAIL shoot_through cyc=%0d Sp=%b Ss=%b required=no leg with both gates on",
                 cyc, bus.Sp, bus.Ss);
      end
      if (obs !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got f/busy/Ss/Sp=%b required=no change", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || e.val !== obs) begin
            errors++;
            $display("FAIL out_change got cyc=%0d f/busy/Ss/Sp=%b required cyc=%0d %b",
                     cyc, obs, e.at, e.val);
          end else begin
            $display("ok   cyc=%0d f/busy/Ss/Sp=%b", cyc, obs);
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    int b;
    bus.en       = 1'b0;
    bus.deadtime = 8'd5;
    bus.V1       = 2'b00;
    bus.V2       = 2'b00;
    tick(3);

    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", obs, 10'b0);
    end else begin
      $display("ok   reset state all outputs low");
    end
    prev   = obs;
    mon_on = 1'b1;

    // Release reset with V1=+1, V2=0, deadtime=5.
    b = cyc;
    rst = 1'b0; bus.en = 1'b1; bus.V1 = 2'b01; bus.V2 = 2'b00; bus.deadtime = 8'd5;
    expect_at(b + 1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    expect_at(b + 6, 1'b0, 1'b0, 4'b1010, 4'b1001);
    tick(26);

    // V1 +1 -> -1: outgoing gates fall two edges later, five-cycle gap.
    b = cyc;
    bus.V1 = 2'b11;
    expect_at(b + 2, 1'b0, 1'b1, 4'b1010, 4'b0000);
    expect_at(b + 7, 1'b0, 1'b0, 4'b1010, 4'b0110);
    tick(27);

`ifndef MIN_ON_TIME_EN
    // deadtime=0 behaves as one cycle; toggle V1 every 10 cycles.
    bus.deadtime = 8'd0;
    for (int i = 0; i < 4; i++) begin
      b = cyc;
      bus.V1 = (i % 2 == 0) ? 2'b01 : 2'b11;
      expect_at(b + 2, 1'b0, 1'b1, 4'b1010, 4'b0000);
      expect_at(b + 3, 1'b0, 1'b0, 4'b1010, (i % 2 == 0) ? 4'b1001 : 4'b0110);
      tick(10);
    end
    tick(10);
`else
    // Minimum on-time: a reversal 2 cycles after A_hi rises is held until 16 on-cycles.
    b = cyc;
    bus.deadtime = 8'd5;
    bus.V1 = 2'b01;
    expect_at(b + 2,  1'b0, 1'b1, 4'b1010, 4'b0000);
    expect_at(b + 7,  1'b0, 1'b0, 4'b1010, 4'b1001);
    tick(9);
    bus.V1 = 2'b11;
    expect_at(b + 23, 1'b0, 1'b1, 4'b1010, 4'b0000);
    expect_at(b + 28, 1'b0, 1'b0, 4'b1010, 4'b0110);
    tick(39);
`endif

    // en dropped mid-DT, re-raised: full 20-cycle DT; a deadtime change mid-count is ignored.
    b = cyc;
    bus.deadtime = 8'd20;
    bus.V1 = 2'b01;
    expect_at(b + 2, 1'b0, 1'b1, 4'b1010, 4'b0000);
    tick(8);
    bus.en = 1'b0;
    expect_at(b + 9, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick(6);
    bus.en = 1'b1;
    expect_at(b + 15, 1'b0, 1'b1, 4'b0000, 4'b0000);
    tick(6);
    bus.deadtime = 8'd3;
    expect_at(b + 35, 1'b0, 1'b0, 4'b1010, 4'b1001);
    tick(25);

    // One-cycle illegal V2 code: sticky fault, gates off until reset, then normal recovery.
    b = cyc;
    bus.V2 = 2'b10;
    tick(1);
    bus.V2 = 2'b00;
    expect_at(b + 2, 1'b1, 1'b0, 4'b0000, 4'b0000);
    tick(24);
    expect_at(b + 25, 1'b0, 1'b0, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_at(b + 28, 1'b0, 1'b1, 4'b0000, 4'b0000);
    expect_at(b + 31, 1'b0, 1'b0, 4'b1010, 4'b1001);
    tick(12);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d still pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
